// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int PIX_W = 8;
  localparam int KSIZE = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index 0 is the top-left byte (win_1), row-major up to index 8 (win_9).
  typedef logic [KSIZE*KSIZE-1:0][PIX_W-1:0] win_t;

endpackage

// File: rtl/conv_line_buffer.sv
// Pixel delay line: dout is the din value presented DEPTH shifts earlier.
// Latency: DEPTH accepted shifts; output is taken straight from the last stage.
// Backpressure: none; the line holds its contents while shift_en is low.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  // Stage 0 holds the newest pixel, stage DEPTH-1 the oldest.
  logic [DEPTH-1:0][PIX_W-1:0] mem_q, mem_d;

  // Shift one stage towards the output on each accepted pixel.
  always_comb begin
    mem_d = mem_q;
    if (shift_en) begin
      mem_d = {mem_q[DEPTH-2:0], din};
    end
  end

  // Storage register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 windows (win_1..win_9, row-major) for the conv MAC.
// Latency: 1 cycle from accepting the bottom-right pixel to win_valid; all outputs registered.
// Backpressure: none; pix_valid=0 freezes all state. WIN_STRIDE2_EN limits windows to even (r,c).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic       sof,
  input  logic [7:0] pix_in,
  output logic       win_valid,
  output logic [7:0] win_1,
  output logic [7:0] win_2,
  output logic [7:0] win_3,
  output logic [7:0] win_4,
  output logic [7:0] win_5,
  output logic [7:0] win_6,
  output logic [7:0] win_7,
  output logic [7:0] win_8,
  output logic [7:0] win_9,
  output logic       frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, cur_col;
  logic [RW-1:0]   row_q, row_d, cur_row;
  win_t            win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            accept;
  logic            emit;
  logic [PIX_W-1:0] lb1_out, lb2_out;

  // lb1 delays by one row (r-1); lb2 chains off lb1 for row r-2.
  conv_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (pix_in),
    .dout     (lb1_out)
  );

  conv_line_buffer #(.DEPTH(WIDTH)) u_lb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (lb1_out),
    .dout     (lb2_out)
  );

  // Acceptance, frame position, window shift and strobes for the next cycle.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    accept       = 1'b0;
    cur_col      = col_q;
    cur_row      = row_q;
    emit         = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a start-of-frame pixel opens a frame; stray pixels are dropped.
        if (pix_valid && sof) begin
          accept  = 1'b1;
          cur_col = '0;
          cur_row = '0;
        end
      end
      RUN: begin
        if (pix_valid) begin
          accept = 1'b1;
          // A fresh sof restarts at (0,0); the old frame never reports done.
          if (sof) begin
            cur_col = '0;
            cur_row = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;

      for (int k = 0; k < KSIZE; k++) begin
        for (int j = 0; j < KSIZE - 1; j++) begin
          win_d[k*KSIZE+j] = win_q[k*KSIZE+j+1];
        end
      end
      win_d[KSIZE-1]         = lb2_out;
      win_d[2*KSIZE-1]       = lb1_out;
      win_d[KSIZE*KSIZE-1]   = pix_in;

      // Line buffers may hold stale rows; the position gate hides them.
      emit = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
`ifdef WIN_STRIDE2_EN
      emit = emit && !cur_col[0] && !cur_row[0];
`else
      emit = emit;
`endif
      win_valid_d = emit;

      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end

      if ((cur_col == COL_LAST) && (cur_row == ROW_LAST)) begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
    end
  end

  // State, counters, window and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_1      = win_q[0];
  assign win_2      = win_q[1];
  assign win_3      = win_q[2];
  assign win_4      = win_q[3];
  assign win_5      = win_q[4];
  assign win_6      = win_q[5];
  assign win_7      = win_q[6];
  assign win_8      = win_q[7];
  assign win_9      = win_q[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen (5x5 frames) against an image-array reference model.
// Latency: expects window/strobes one clock after the accepting edge.
// Backpressure: exercises pix_valid gaps, stray sof and mid-frame restarts/resets.
module tb_conv_window_gen;

  localparam int W = 5;
  localparam int H = 5;
`ifdef WIN_STRIDE2_EN
  localparam bit STRIDE2  = 1'b1;
  localparam int EXP_WINS = 4;
`else
  localparam bit STRIDE2  = 1'b0;
  localparam int EXP_WINS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_valid;
  logic       sof;
  logic [7:0] pix_in;
  logic       win_valid;
  logic [7:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;
  logic       frame_done;

  conv_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .pix_in     (pix_in),
    .win_valid  (win_valid),
    .win_1      (win_1),
    .win_2      (win_2),
    .win_3      (win_3),
    .win_4      (win_4),
    .win_5      (win_5),
    .win_6      (win_6),
    .win_7      (win_7),
    .win_8      (win_8),
    .win_9      (win_9),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;

  // Reference model: frame position plus the pixels of the current frame.
  bit          m_run;
  int          m_r, m_c;
  logic [7:0]  img [H][W];
  bit          exp_vld, exp_done;
  logic [71:0] exp_win, held_win;
  bit          held_known;
  int          win_cnt, done_cnt, mark_idx;
  logic [71:0] first_win, mark_win;

  function automatic logic [71:0] got_win();
    return {win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9};
  endfunction

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run      = 1'b0;
    m_r        = 0;
    m_c        = 0;
    held_known = 1'b0;
    exp_vld    = 1'b0;
    exp_done   = 1'b0;
  endtask

  task automatic model(input bit v, input bit s, input logic [7:0] p);
    bit acc;
    acc      = 1'b0;
    exp_vld  = 1'b0;
    exp_done = 1'b0;
    if (v && s) begin
      m_r = 0;
      m_c = 0;
      acc = 1'b1;
    end else if (v && m_run) begin
      acc = 1'b1;
    end
    if (acc) begin
      m_run        = 1'b1;
      held_known   = 1'b0;
      img[m_r][m_c] = p;
      if (m_r >= 2 && m_c >= 2 && (!STRIDE2 || (m_r % 2 == 0 && m_c % 2 == 0))) begin
        exp_vld = 1'b1;
        exp_win = '0;
        for (int rr = m_r - 2; rr <= m_r; rr++)
          for (int cc = m_c - 2; cc <= m_c; cc++)
            exp_win = {exp_win[63:0], img[rr][cc]};
      end
      if (m_r == H - 1 && m_c == W - 1) begin
        exp_done = 1'b1;
        m_run    = 1'b0;
      end
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r++;
        if (m_r == H) m_r = 0;
      end
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] p);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    model(v, s, p);
    @(posedge clk);
    #1;
    check_eq("win_valid", 72'(win_valid), 72'(exp_vld));
    check_eq("frame_done", 72'(frame_done), 72'(exp_done));
    if (exp_vld) check_eq("window", got_win(), exp_win);
    else if (held_known) check_eq("hold", got_win(), held_win);
    if (exp_vld) begin
      held_win   = exp_win;
      held_known = 1'b1;
    end
    if (win_valid) begin
      win_cnt++;
      if (win_cnt == 1) first_win = got_win();
      if (win_cnt == mark_idx) mark_win = got_win();
    end
    if (frame_done) done_cnt++;
  endtask

  task automatic send_frame(input int base, input bit ramp, input int gap_pct, input int npix);
    for (int i = 0; i < npix; i++) begin
      for (int j = 0; j < 8 && int'($urandom_range(99)) < gap_pct; j++)
        step(1'b0, 1'($urandom_range(1)), 8'($urandom));
      step(1'b1, i == 0, ramp ? 8'(base + i) : 8'($urandom));
    end
  endtask

  task automatic clear_counts();
    win_cnt  = 0;
    done_cnt = 0;
    mark_idx = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_win_valid", 72'(win_valid), 72'(0));
    check_eq("rst_frame_done", 72'(frame_done), 72'(0));
    check_eq("rst_window", got_win(), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Pixels before any sof are ignored.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom));
    check_eq("pre_sof_wins", 72'(win_cnt), 72'(0));

    // Continuous ramp frame.
    clear_counts();
    send_frame(0, 1'b1, 0, W * H);
    check_eq("f1_count", 72'(win_cnt), 72'(EXP_WINS));
    check_eq("f1_first", first_win, 72'h00_01_02_05_06_07_0a_0b_0c);
    check_eq("f1_done", 72'(done_cnt), 72'(1));
    step(1'b0, 1'b0, 8'h0);
    step(1'b0, 1'b0, 8'h0);

    // Same ramp with random gaps.
    clear_counts();
    send_frame(0, 1'b1, 50, W * H);
    check_eq("f2_count", 72'(win_cnt), 72'(EXP_WINS));
    check_eq("f2_first", first_win, 72'h00_01_02_05_06_07_0a_0b_0c);

    // Restart after 8 pixels, then a full frame.
    clear_counts();
    send_frame(0, 1'b0, 20, 8);
    send_frame(0, 1'b0, 20, W * H);
    check_eq("abort_count", 72'(win_cnt), 72'(EXP_WINS));
    check_eq("abort_done", 72'(done_cnt), 72'(1));

    // Back-to-back frames with zero bubble.
    clear_counts();
    mark_idx = EXP_WINS + 1;
    send_frame(0, 1'b1, 0, W * H);
    send_frame(100, 1'b1, 0, W * H);
    check_eq("b2b_count", 72'(win_cnt), 72'(2 * EXP_WINS));
    check_eq("b2b_done", 72'(done_cnt), 72'(2));
    check_eq("b2b_second_first", mark_win, 72'h64_65_66_69_6a_6b_6e_6f_70);

    // Random frames with gaps and occasional early restarts.
    for (int f = 0; f < 6; f++) begin
      send_frame(0, 1'b0, 30, ($urandom_range(3) == 0) ? int'($urandom_range(24, 1)) : W * H);
    end
    step(1'b0, 1'b0, 8'h0);

    // Asynchronous reset mid-frame, just after a window was emitted.
    send_frame(0, 1'b1, 0, 13);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_win_valid", 72'(win_valid), 72'(0));
    check_eq("arst_frame_done", 72'(frame_done), 72'(0));
    check_eq("arst_window", got_win(), 72'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery frame after reset.
    clear_counts();
    send_frame(0, 1'b1, 25, W * H);
    check_eq("post_rst_count", 72'(win_cnt), 72'(EXP_WINS));
    check_eq("post_rst_done", 72'(done_cnt), 72'(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
